// File: rtl/elastic_mul_pipe_pkg.sv
// Shared helpers for the elastic multiplier: ceiling log2 and product width resizing.
package elastic_mul_pipe_pkg;

  localparam int DEFAULT_DATA_SIZE_IN = 8;
  localparam int PROD_W               = 2 * DEFAULT_DATA_SIZE_IN;
  localparam int RESIZE_MAX_W         = 128;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Extends a src_w-bit value to RESIZE_MAX_W bits; callers truncate to their width.
  function automatic logic [RESIZE_MAX_W-1:0] resize_ext(input logic [RESIZE_MAX_W-1:0] value,
                                                         input int src_w,
                                                         input logic sgn);
    logic [RESIZE_MAX_W-1:0] result;
    result = value;
    for (int i = 0; i < RESIZE_MAX_W; i++) begin
      if (i >= src_w) begin
        result[i] = sgn & value[src_w-1];
      end else begin
        result[i] = value[i];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/elastic_fifo_sa.sv
// Show-ahead FIFO with compare-and-wrap pointers, so any depth >= 1 works.
module elastic_fifo_sa
  import elastic_mul_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head,
  output logic                          full,
  output logic                          empty,
  output logic [clog2(DEPTH + 1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push_s = push & (~full | do_pop_s);

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage; entries are only observed while the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/elastic_mul_pipe_chk.sv
// Invariants of the credit scheme: no write into a full FIFO, credits bounded by depth.
module elastic_mul_pipe_chk #(
  parameter int FIFO_DEPTH = 6,
  parameter int CNT_W      = 3
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic             full,
  input logic [CNT_W-1:0] outstanding,
  input logic [CNT_W-1:0] fifo_count
);

  push_never_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
  credit_bound:    assert property (@(posedge clk) disable iff (rst) outstanding <= CNT_W'(FIFO_DEPTH));
  buffered_within: assert property (@(posedge clk) disable iff (rst) fifo_count <= outstanding);

endmodule

// File: rtl/elastic_mul_pipe.sv
// Elastic multiplier: free-running pipeline, show-ahead result FIFO and credit-gated admission,
// so downstream ready never reaches operand ready combinationally.
module elastic_mul_pipe
  import elastic_mul_pipe_pkg::*;
#(
  parameter int DATA_SIZE_IN  = 8,
  parameter int DATA_SIZE_OUT = 16,
  parameter int LATENCY       = 4,
  parameter int FIFO_DEPTH    = 6,
  parameter int SIGNED        = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_SIZE_IN-1:0]  dataInArray_0,
  input  logic [DATA_SIZE_IN-1:0]  dataInArray_1,
  input  logic [1:0]               pValidArray,
  output logic [1:0]               readyArray,
  output logic [DATA_SIZE_OUT-1:0] dataOutArray,
  output logic                     validArray,
  input  logic                     nReadyArray
);

  localparam int PW    = 2 * DATA_SIZE_IN;
  localparam int CNT_W = clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0]        outstanding_r;
  logic [DATA_SIZE_IN-1:0] a_r;
  logic [DATA_SIZE_IN-1:0] b_r;
  logic [LATENCY-1:0]      stage_valid_r;
  logic                    can_accept_s;
  logic                    accept_s;
  logic                    pop_s;
  logic                    push_s;
  logic [PW-1:0]           a_ext_s;
  logic [PW-1:0]           b_ext_s;
  logic [PW-1:0]           prod_s;
  logic [PW-1:0]           last_data_s;
  logic [PW-1:0]           head_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [CNT_W-1:0]        fifo_count_s;

  assign can_accept_s = (outstanding_r < CNT_W'(FIFO_DEPTH));
  assign accept_s     = ~rst & can_accept_s & pValidArray[0] & pValidArray[1];
  assign readyArray   = {~rst & can_accept_s & pValidArray[0], ~rst & can_accept_s & pValidArray[1]};
  assign validArray   = ~fifo_empty_s;
  assign pop_s        = validArray & nReadyArray;
  assign push_s       = stage_valid_r[LATENCY-1];

  // Full-width operands so one multiplier serves both signed and unsigned modes.
  assign a_ext_s = {{DATA_SIZE_IN{(SIGNED != 0) & a_r[DATA_SIZE_IN-1]}}, a_r};
  assign b_ext_s = {{DATA_SIZE_IN{(SIGNED != 0) & b_r[DATA_SIZE_IN-1]}}, b_r};
  assign prod_s  = a_ext_s * b_ext_s;

  // Credit counter: in-flight plus buffered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_r <= '0;
    end else begin
      case ({accept_s, pop_s})
        2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
        2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Stage 0 operand capture and the valid shift chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r           <= '0;
      b_r           <= '0;
      stage_valid_r <= '0;
    end else begin
      if (accept_s) begin
        a_r <= dataInArray_0;
        b_r <= dataInArray_1;
      end
      stage_valid_r[0] <= accept_s;
      for (int i = 1; i < LATENCY; i++) begin
        stage_valid_r[i] <= stage_valid_r[i-1];
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      assign last_data_s = prod_s;
    end else begin : g_latn
      logic [PW-1:0] stage_data_r [1:LATENCY-1];

      // Product carry stages
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 1; i < LATENCY; i++) begin
            stage_data_r[i] <= '0;
          end
        end else begin
          stage_data_r[1] <= prod_s;
          for (int i = 2; i < LATENCY; i++) begin
            stage_data_r[i] <= stage_data_r[i-1];
          end
        end
      end

      assign last_data_s = stage_data_r[LATENCY-1];
    end
  endgenerate

  elastic_fifo_sa #(
    .DATA_WIDTH (PW),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (last_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Output resize; forced to zero while empty so reset and idle read as 0
  always_comb begin
    dataOutArray = '0;
    if (validArray) begin
      dataOutArray = DATA_SIZE_OUT'(resize_ext(RESIZE_MAX_W'(head_s), PW, 1'(SIGNED != 0)));
    end else begin
      dataOutArray = '0;
    end
  end

  elastic_mul_pipe_chk #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .push        (push_s),
    .full        (fifo_full_s),
    .outstanding (outstanding_r),
    .fifo_count  (fifo_count_s)
  );

endmodule

// File: tb/tb_elastic_mul_pipe.sv
// Directed bench for elastic_mul_pipe: unsigned and signed instances driven by the same stimulus.
module tb_elastic_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  pv;
  logic        nr;
  logic [1:0]  ready_u;
  logic [1:0]  ready_s;
  logic [15:0] dout_u;
  logic [15:0] dout_s;
  logic        valid_u;
  logic        valid_s;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  elastic_mul_pipe #(
    .DATA_SIZE_IN(8), .DATA_SIZE_OUT(16), .LATENCY(4), .FIFO_DEPTH(6), .SIGNED(0)
  ) dut (
    .clk(clk), .rst(rst), .dataInArray_0(a), .dataInArray_1(b), .pValidArray(pv),
    .readyArray(ready_u), .dataOutArray(dout_u), .validArray(valid_u), .nReadyArray(nr)
  );

  elastic_mul_pipe #(
    .DATA_SIZE_IN(8), .DATA_SIZE_OUT(16), .LATENCY(4), .FIFO_DEPTH(6), .SIGNED(1)
  ) dut_s (
    .clk(clk), .rst(rst), .dataInArray_0(a), .dataInArray_1(b), .pValidArray(pv),
    .readyArray(ready_s), .dataOutArray(dout_s), .validArray(valid_s), .nReadyArray(nr)
  );

  task automatic test_reset();
    rst = 1'b1; a = 8'd0; b = 8'd0; pv = 2'b11; nr = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (valid_u !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_u); end
    checks++; if (ready_u !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", ready_u); end
    checks++; if (dout_u !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h want 0000", dout_u); end
    rst = 1'b0; pv = 2'b00;
    #1;
    checks++; if (valid_u !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", valid_u); end
  endtask

  task automatic test_single();
    logic exp_v;
    @(negedge clk);
    a = 8'd13; b = 8'd11; pv = 2'b11; nr = 1'b1;
    #1;
    checks++; if (ready_u !== 2'b11) begin errors++; $display("FAIL single_ready: got %b want 11", ready_u); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      pv = 2'b00;
      exp_v = (k == 5);
      checks++; if (valid_u !== exp_v) begin errors++; $display("FAIL single_valid k=%0d: got %b want %b", k, valid_u, exp_v); end
      if (k == 5) begin
        checks++; if (dout_u !== 16'd143) begin errors++; $display("FAIL single_dout: got %0d want 143", dout_u); end
      end
    end
  endtask

  task automatic test_signed();
    logic exp_v;
    @(negedge clk);
    a = 8'hFD; b = 8'h05; pv = 2'b11; nr = 1'b1;
    #1;
    checks++; if (ready_s !== 2'b11) begin errors++; $display("FAIL signed_ready: got %b want 11", ready_s); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      pv = 2'b00;
      exp_v = (k == 5);
      checks++; if (valid_s !== exp_v) begin errors++; $display("FAIL signed_valid k=%0d: got %b want %b", k, valid_s, exp_v); end
      if (k == 5) begin
        checks++; if (dout_s !== 16'hFFF1) begin errors++; $display("FAIL signed_dout: got %h want fff1", dout_s); end
        checks++; if (dout_u !== 16'h04F1) begin errors++; $display("FAIL unsigned_dout: got %h want 04f1", dout_u); end
      end
    end
  endtask

  task automatic test_join();
    logic exp_v;
    @(negedge clk);
    a = 8'd7; b = 8'd9; pv = 2'b01; nr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (ready_u !== 2'b10) begin errors++; $display("FAIL join_ready k=%0d: got %b want 10", k, ready_u); end
      checks++; if (valid_u !== 1'b0) begin errors++; $display("FAIL join_valid k=%0d: got %b want 0", k, valid_u); end
      @(negedge clk);
    end
    pv = 2'b11;
    #1;
    checks++; if (ready_u !== 2'b11) begin errors++; $display("FAIL join_accept_ready: got %b want 11", ready_u); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      pv = 2'b00;
      exp_v = (k == 5);
      checks++; if (valid_u !== exp_v) begin errors++; $display("FAIL join_res_valid k=%0d: got %b want %b", k, valid_u, exp_v); end
      if (k == 5) begin
        checks++; if (dout_u !== 16'd63) begin errors++; $display("FAIL join_dout: got %0d want 63", dout_u); end
      end
    end
  endtask

  task automatic test_stream();
    logic        exp_v;
    logic [15:0] exp_d;
    nr = 1'b1;
    for (int cyc = 0; cyc < 28; cyc++) begin
      @(negedge clk);
      exp_v = (cyc >= 5 && cyc < 25);
      checks++; if (valid_u !== exp_v) begin errors++; $display("FAIL stream_valid cyc=%0d: got %b want %b", cyc, valid_u, exp_v); end
      if (exp_v) begin
        exp_d = 16'((cyc - 5) * (cyc - 4));
        checks++; if (dout_u !== exp_d) begin errors++; $display("FAIL stream_dout cyc=%0d: got %0d want %0d", cyc, dout_u, exp_d); end
      end
      if (cyc < 20) begin
        a = 8'(cyc); b = 8'(cyc + 1); pv = 2'b11;
        #1;
        checks++; if (ready_u !== 2'b11) begin errors++; $display("FAIL stream_ready cyc=%0d: got %b want 11", cyc, ready_u); end
      end else begin
        pv = 2'b00;
      end
    end
  endtask

  task automatic test_backpressure();
    logic        exp_v;
    logic [15:0] exp_d;
    logic [1:0]  exp_r;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      @(negedge clk);
      exp_v = (cyc >= 5 && cyc <= 18);
      if (cyc <= 12) exp_d = 16'd30;
      else if (cyc <= 17) exp_d = 16'(30 + 3 * (cyc - 12));
      else exp_d = 16'd100;
      checks++; if (valid_u !== exp_v) begin errors++; $display("FAIL bp_valid cyc=%0d: got %b want %b", cyc, valid_u, exp_v); end
      if (exp_v) begin
        checks++; if (dout_u !== exp_d) begin errors++; $display("FAIL bp_dout cyc=%0d: got %0d want %0d", cyc, dout_u, exp_d); end
      end
      if (cyc < 12) begin
        a = 8'(10 + cyc); b = 8'd3; pv = 2'b11; nr = 1'b0;
        exp_r = (cyc < 6) ? 2'b11 : 2'b00;
      end else if (cyc < 14) begin
        a = 8'd50; b = 8'd2; pv = 2'b11; nr = 1'b1;
        exp_r = (cyc == 12) ? 2'b00 : 2'b11;
      end else begin
        pv = 2'b00; nr = 1'b1;
        exp_r = 2'b00;
      end
      #1;
      checks++; if (ready_u !== exp_r) begin errors++; $display("FAIL bp_ready cyc=%0d: got %b want %b", cyc, ready_u, exp_r); end
    end
  endtask

  task automatic test_reset_midflight();
    logic exp_v;
    nr = 1'b0;
    for (int cyc = 0; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc < 3) begin
        a = 8'(cyc + 2); b = 8'd5; pv = 2'b11;
      end else begin
        pv = 2'b00;
      end
    end
    checks++; if (valid_u !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", valid_u); end
    rst = 1'b1; pv = 2'b11;
    #1;
    checks++; if (valid_u !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", valid_u); end
    checks++; if (ready_u !== 2'b00) begin errors++; $display("FAIL mid_rst_ready: got %b want 00", ready_u); end
    checks++; if (dout_u !== 16'h0000) begin errors++; $display("FAIL mid_rst_dout: got %h want 0000", dout_u); end
    @(negedge clk);
    rst = 1'b0; nr = 1'b1; a = 8'd6; b = 8'd7; pv = 2'b11;
    #1;
    checks++; if (ready_u !== 2'b11) begin errors++; $display("FAIL mid_post_ready: got %b want 11", ready_u); end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      pv = 2'b00;
      exp_v = (k == 5);
      checks++; if (valid_u !== exp_v) begin errors++; $display("FAIL mid_post_valid k=%0d: got %b want %b", k, valid_u, exp_v); end
      if (k == 5) begin
        checks++; if (dout_u !== 16'd42) begin errors++; $display("FAIL mid_post_dout: got %0d want 42", dout_u); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_join();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
